// File: rtl/mem_ctrl_rr.sv
// mem_ctrl_rr: buffers one request per channel, arbitrates round-robin onto main memory, routes read responses back by channel ID (MEM_CTRL_RR_PERF_EN adds grant/stall counters)
module mem_ctrl_rr #(
  parameter int N_CHAN = 2,
  parameter int ADDR_W = 32,
  parameter int BLOCK_BYTES = 8,
  localparam int BLOCK_DATA_W = 8 * BLOCK_BYTES,
  localparam int BLOCK_ADDR_W = ADDR_W - $clog2(BLOCK_BYTES),
  localparam int CHAN_ID_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                           clk,
  input  logic                           rst_aL,
  input  logic [N_CHAN-1:0]              req_valid,
  input  logic [N_CHAN-1:0]              req_type,
  input  logic [N_CHAN*BLOCK_ADDR_W-1:0] req_block_addr,
  input  logic [N_CHAN*BLOCK_DATA_W-1:0] req_block_data,
  output logic [N_CHAN-1:0]              req_ready,
  output logic [N_CHAN-1:0]              resp_valid,
  output logic [BLOCK_DATA_W-1:0]        resp_block_data,
  output logic                           mem_req_valid,
  output logic [CHAN_ID_W-1:0]           mem_req_chan_id,
  output logic                           mem_req_type,
  output logic [BLOCK_ADDR_W-1:0]        mem_req_block_addr,
  output logic [BLOCK_DATA_W-1:0]        mem_req_block_data,
  input  logic                           mem_resp_valid,
  input  logic [CHAN_ID_W-1:0]           mem_resp_chan_id,
  input  logic [BLOCK_DATA_W-1:0]        mem_resp_block_data,
  output logic                           err_unexpected_resp
`ifdef MEM_CTRL_RR_PERF_EN
  ,
  output logic [N_CHAN*32-1:0]           perf_grant_cnt,
  output logic [N_CHAN*32-1:0]           perf_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, PEND, WAIT_RESP} state_e;
  state_e                  state_q [N_CHAN];
  state_e                  state_d [N_CHAN];
  logic [N_CHAN-1:0]       type_q, type_d;
  logic [BLOCK_ADDR_W-1:0] addr_q [N_CHAN];
  logic [BLOCK_ADDR_W-1:0] addr_d [N_CHAN];
  logic [BLOCK_DATA_W-1:0] data_q [N_CHAN];
  logic [BLOCK_DATA_W-1:0] data_d [N_CHAN];
  logic [CHAN_ID_W-1:0]    ptr_q, ptr_d;
  logic                    grant_any;
  logic [CHAN_ID_W-1:0]    grant_idx;
  logic [N_CHAN-1:0]       grant, hit;
  logic                    mem_req_valid_q, mem_req_valid_d;
  logic [CHAN_ID_W-1:0]    mem_req_chan_id_q, mem_req_chan_id_d;
  logic                    mem_req_type_q, mem_req_type_d;
  logic [BLOCK_ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [BLOCK_DATA_W-1:0] mem_req_data_q, mem_req_data_d;
  logic [N_CHAN-1:0]       resp_valid_q, resp_valid_d;
  logic [BLOCK_DATA_W-1:0] resp_data_q, resp_data_d;
  logic                    err_q, err_d;

  // Round-robin search for the first pending channel after the last grant
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_CHAN; k++) begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (!grant_any && state_q[i] == PEND && i == (int'(ptr_q) + k) % N_CHAN) begin
          grant_any = 1'b1;
          grant_idx = CHAN_ID_W'(i);
        end
      end
    end
    for (int i = 0; i < N_CHAN; i++) grant[i] = grant_any && grant_idx == CHAN_ID_W'(i);
    ptr_d = grant_any ? grant_idx : ptr_q;
  end

  // Per-channel request buffer and IDLE/PEND/WAIT_RESP sequencing
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      hit[i] = mem_resp_valid && mem_resp_chan_id == CHAN_ID_W'(i) && state_q[i] == WAIT_RESP;
      req_ready[i] = state_q[i] == IDLE;
      state_d[i] = state_q[i];
      type_d[i] = type_q[i];
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (state_q[i] == IDLE && req_valid[i]) begin
        state_d[i] = PEND;
        type_d[i] = req_type[i];
        addr_d[i] = req_block_addr[i*BLOCK_ADDR_W +: BLOCK_ADDR_W];
        data_d[i] = req_block_data[i*BLOCK_DATA_W +: BLOCK_DATA_W];
      end
      if (grant[i]) state_d[i] = type_q[i] ? IDLE : WAIT_RESP;
      if (hit[i]) state_d[i] = IDLE;
    end
  end

  // Next values of the registered memory request, response pulse and sticky error
  always_comb begin
    mem_req_valid_d = grant_any;
    mem_req_chan_id_d = grant_idx;
    mem_req_type_d = 1'b0;
    mem_req_addr_d = '0;
    mem_req_data_d = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (grant[i]) begin
        mem_req_type_d = type_q[i];
        mem_req_addr_d = addr_q[i];
        mem_req_data_d = data_q[i];
      end
    end
    resp_valid_d = hit;
    resp_data_d = |hit ? mem_resp_block_data : '0;
    err_d = err_q | (mem_resp_valid & ~|hit);
  end

  // State registers; reset drops every buffered and in-flight request
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int i = 0; i < N_CHAN; i++) begin
        state_q[i] <= IDLE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      type_q <= '0;
      ptr_q <= CHAN_ID_W'(N_CHAN - 1);
      mem_req_valid_q <= 1'b0;
      mem_req_chan_id_q <= '0;
      mem_req_type_q <= 1'b0;
      mem_req_addr_q <= '0;
      mem_req_data_q <= '0;
      resp_valid_q <= '0;
      resp_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        state_q[i] <= state_d[i];
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      type_q <= type_d;
      ptr_q <= ptr_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_chan_id_q <= mem_req_chan_id_d;
      mem_req_type_q <= mem_req_type_d;
      mem_req_addr_q <= mem_req_addr_d;
      mem_req_data_q <= mem_req_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q <= resp_data_d;
      err_q <= err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_chan_id = mem_req_chan_id_q;
  assign mem_req_type = mem_req_type_q;
  assign mem_req_block_addr = mem_req_addr_q;
  assign mem_req_block_data = mem_req_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_block_data = resp_data_q;
  assign err_unexpected_resp = err_q;

`ifdef MEM_CTRL_RR_PERF_EN
  logic [31:0] grant_cnt_q [N_CHAN];
  logic [31:0] grant_cnt_d [N_CHAN];
  logic [31:0] stall_cnt_q [N_CHAN];
  logic [31:0] stall_cnt_d [N_CHAN];

  // Saturating per-channel grant and pending-without-grant counters
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i] + 32'(grant[i] && grant_cnt_q[i] != '1);
      stall_cnt_d[i] = stall_cnt_q[i] + 32'(state_q[i] == PEND && !grant[i] && stall_cnt_q[i] != '1);
      perf_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
      perf_stall_cnt[i*32 +: 32] = stall_cnt_q[i];
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int i = 0; i < N_CHAN; i++) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
    end
  end
`endif
endmodule

// File: tb/tb_mem_ctrl_rr.sv
// tb_mem_ctrl_rr: scoreboard bench for mem_ctrl_rr with four channels
module tb_mem_ctrl_rr;
  localparam int N = 4;
  localparam int AW = 29;
  localparam int DW = 64;
  localparam int CW = 2;

  typedef struct {
    int         ch;
    logic       typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int         cyc;
  } mem_t;

  typedef struct {
    int         ch;
    logic [DW-1:0] data;
    int         cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_type = '0;
  logic [N*AW-1:0] req_block_addr = '0;
  logic [N*DW-1:0] req_block_data = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] resp_valid;
  logic [DW-1:0] resp_block_data;
  logic mem_req_valid;
  logic [CW-1:0] mem_req_chan_id;
  logic mem_req_type;
  logic [AW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_block_data;
  logic mem_resp_valid = 1'b0;
  logic [CW-1:0] mem_resp_chan_id = '0;
  logic [DW-1:0] mem_resp_block_data = '0;
  logic err;
`ifdef MEM_CTRL_RR_PERF_EN
  logic [N*32-1:0] perf_grant_cnt;
  logic [N*32-1:0] perf_stall_cnt;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  mem_t exp_mem[$];
  resp_t exp_resp[$];

  mem_ctrl_rr #(.N_CHAN(N), .ADDR_W(32), .BLOCK_BYTES(8)) dut (
    .clk(clk),
    .rst_aL(rst_aL),
    .req_valid(req_valid),
    .req_type(req_type),
    .req_block_addr(req_block_addr),
    .req_block_data(req_block_data),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_block_data(resp_block_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_chan_id(mem_req_chan_id),
    .mem_req_type(mem_req_type),
    .mem_req_block_addr(mem_req_block_addr),
    .mem_req_block_data(mem_req_block_data),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_chan_id(mem_resp_chan_id),
    .mem_resp_block_data(mem_resp_block_data),
    .err_unexpected_resp(err)
`ifdef MEM_CTRL_RR_PERF_EN
    ,
    .perf_grant_cnt(perf_grant_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_chan(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_block_addr[ch*AW +: AW] = a;
    req_block_data[ch*DW +: DW] = d;
  endtask

  task automatic push_mem(input int ch, input logic typ, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    mem_t e;
    e.ch = ch;
    e.typ = typ;
    e.addr = a;
    e.data = d;
    e.cyc = c;
    exp_mem.push_back(e);
  endtask

  task automatic req(input logic [N-1:0] mask, input logic [N-1:0] typ);
    req_valid = mask;
    req_type = typ;
    step(1);
    req_valid = '0;
    req_type = '0;
  endtask

  task automatic mresp(input int ch, input logic [DW-1:0] d, input bit ok);
    resp_t r;
    mem_resp_valid = 1'b1;
    mem_resp_chan_id = CW'(ch);
    mem_resp_block_data = d;
    if (ok) begin
      r.ch = ch;
      r.data = d;
      r.cyc = cyc + 1;
      exp_resp.push_back(r);
    end
    step(1);
    mem_resp_valid = 1'b0;
    mem_resp_chan_id = '0;
    mem_resp_block_data = '0;
  endtask

  always @(negedge clk) begin : monitor
    mem_t e;
    resp_t r;
    if (mem_req_valid) begin
      chk("mem_req_expected", 128'(exp_mem.size() != 0), 128'(1));
      if (exp_mem.size() != 0) begin
        e = exp_mem.pop_front();
        chk("mem_req_cycle", 128'(cyc), 128'(e.cyc));
        chk("mem_req_chan", 128'(mem_req_chan_id), 128'(e.ch));
        chk("mem_req_type", 128'(mem_req_type), 128'(e.typ));
        chk("mem_req_addr", 128'(mem_req_block_addr), 128'(e.addr));
        chk("mem_req_data", 128'(mem_req_block_data), 128'(e.data));
      end
    end else begin
      chk("mem_req_idle_zero", {mem_req_chan_id, mem_req_type, mem_req_block_addr, mem_req_block_data}, 128'(0));
    end
    if (resp_valid != '0) begin
      chk("resp_expected", 128'(exp_resp.size() != 0), 128'(1));
      if (exp_resp.size() != 0) begin
        r = exp_resp.pop_front();
        chk("resp_cycle", 128'(cyc), 128'(r.cyc));
        chk("resp_valid_onehot", 128'(resp_valid), 128'(1) << r.ch);
        chk("resp_data", 128'(resp_block_data), 128'(r.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(4'hF));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_data", 128'(resp_block_data), 128'(0));
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    step(2);
    rst_aL = 1'b1;
    step(2);

    // four reads at once: grants 0,1,2,3 on consecutive cycles
    for (int i = 0; i < N; i++) set_chan(i, AW'(32'h100 * (i + 1)), '0);
    c0 = cyc;
    for (int i = 0; i < N; i++) push_mem(i, 1'b0, AW'(32'h100 * (i + 1)), '0, c0 + 2 + i);
    req(4'hF, 4'h0);
    chk("contend_ready_low", 128'(req_ready), 128'(0));
    step(5);
    mresp(0, 64'hA0A0_0000_0000_0001, 1'b1);
    mresp(2, 64'hA2A2_0000_0000_0003, 1'b1);
    chk("contend_ready_0_2", 128'(req_ready), 128'(4'b0101));
    // ch0 and ch2 again: pointer at 3 wraps so ch0 precedes ch2
    set_chan(0, AW'(32'h700), '0);
    set_chan(2, AW'(32'h900), '0);
    c0 = cyc;
    push_mem(0, 1'b0, AW'(32'h700), '0, c0 + 2);
    push_mem(2, 1'b0, AW'(32'h900), '0, c0 + 3);
    req(4'b0101, 4'h0);
    step(4);
    mresp(1, 64'hA1A1_0000_0000_0002, 1'b1);
    mresp(3, 64'hA3A3_0000_0000_0004, 1'b1);
    mresp(0, 64'hB0B0_0000_0000_0005, 1'b1);
    mresp(2, 64'hB2B2_0000_0000_0006, 1'b1);
    step(1);
    chk("contend_all_idle", 128'(req_ready), 128'(4'hF));

    // single read on ch0
    set_chan(0, AW'(32'h1000), '0);
    c0 = cyc;
    push_mem(0, 1'b0, AW'(32'h1000), '0, c0 + 2);
    req(4'b0001, 4'h0);
    chk("rd_ready_low_t1", 128'(req_ready[0]), 128'(0));
    step(1);
    chk("rd_ready_low_t2", 128'(req_ready[0]), 128'(0));
    step(2);
    chk("rd_ready_low_wait", 128'(req_ready[0]), 128'(0));
    mresp(0, 64'hDEADBEEF_CAFEF00D, 1'b1);
    chk("rd_ready_back", 128'(req_ready[0]), 128'(1));
    chk("rd_resp_pulse", 128'(resp_valid), 128'(4'b0001));
    step(1);
    chk("rd_resp_one_cycle", 128'(resp_valid), 128'(0));

    // posted write on ch1
    set_chan(1, AW'(32'h2000), 64'h1122334455667788);
    c0 = cyc;
    push_mem(1, 1'b1, AW'(32'h2000), 64'h1122334455667788, c0 + 2);
    req(4'b0010, 4'b0010);
    chk("wr_ready_low", 128'(req_ready[1]), 128'(0));
    step(1);
    chk("wr_ready_back", 128'(req_ready[1]), 128'(1));
    set_chan(1, '0, '0);
    step(4);

    // spurious response to idle ch1
    mresp(1, 64'h5555, 1'b0);
    chk("spur_err_set", 128'(err), 128'(1));
    chk("spur_no_resp", 128'(resp_valid), 128'(0));
    step(5);
    chk("spur_err_sticky", 128'(err), 128'(1));

    // reset while ch0 waits for its response
    set_chan(0, AW'(32'h3000), '0);
    c0 = cyc;
    push_mem(0, 1'b0, AW'(32'h3000), '0, c0 + 2);
    req(4'b0001, 4'h0);
    step(2);
    chk("mid_wait_ready", 128'(req_ready[0]), 128'(0));
    rst_aL = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(req_ready), 128'(4'hF));
    chk("mid_rst_resp", 128'(resp_valid), 128'(0));
    chk("mid_rst_mem_valid", 128'(mem_req_valid), 128'(0));
    chk("mid_rst_err", 128'(err), 128'(0));
    step(2);
    rst_aL = 1'b1;
    step(1);
    chk("post_rst_ready", 128'(req_ready), 128'(4'hF));
    mresp(0, 64'h7777, 1'b0);
    chk("late_resp_err", 128'(err), 128'(1));

    // ch0 and ch1 contend for three rounds; ch0 first each round
    for (int r = 0; r < 3; r++) begin
      set_chan(0, AW'(32'h4000 + r), '0);
      set_chan(1, AW'(32'h5000 + r), '0);
      c0 = cyc;
      push_mem(0, 1'b0, AW'(32'h4000 + r), '0, c0 + 2);
      push_mem(1, 1'b0, AW'(32'h5000 + r), '0, c0 + 3);
      req(4'b0011, 4'h0);
      step(3);
      mresp(0, 64'hC000 + 64'(r), 1'b1);
      mresp(1, 64'hD000 + 64'(r), 1'b1);
      step(1);
    end
`ifdef MEM_CTRL_RR_PERF_EN
    chk("perf_grant0", 128'(perf_grant_cnt[31:0]), 128'(3));
    chk("perf_grant1", 128'(perf_grant_cnt[63:32]), 128'(3));
    chk("perf_grant23", 128'(perf_grant_cnt[127:64]), 128'(0));
    chk("perf_stall0", 128'(perf_stall_cnt[31:0]), 128'(0));
    chk("perf_stall1", 128'(perf_stall_cnt[63:32]), 128'(3));
`endif
    chk("err_still_set", 128'(err), 128'(1));
    step(3);
    chk("exp_mem_drained", 128'(exp_mem.size()), 128'(0));
    chk("exp_resp_drained", 128'(exp_resp.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
